helo_scroll_ctrl: RTL and testbench

HELO_SCROLL_CTRL -- requirements
Module: helo_scroll_ctrl

---
 rtl/helo_pkg.sv | 20 ++
 rtl/helo_tick_gen.sv | 28 ++
 rtl/helo_scroll_ctrl.sv | 70 +++++++
 tb/tb_helo_scroll_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/helo_pkg.sv
// helo_pkg: symbol codes, scroll FSM states and the base HELLO message
package helo_pkg;

    typedef enum logic [2:0] {
        SYM_BLANK = 3'b000,
        SYM_H     = 3'b001,
        SYM_E     = 3'b010,
        SYM_L     = 3'b011,
        SYM_O     = 3'b100
    } sym_e;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Displays 7..0 at Pos=0: H E L L O _ _ _
    localparam logic [23:0] BASE_MSG = {SYM_H, SYM_E, SYM_L, SYM_L, SYM_O, SYM_BLANK, SYM_BLANK, SYM_BLANK};

endpackage

// File: rtl/helo_tick_gen.sv
// helo_tick_gen: clear/enable divider producing one terminal-count pulse every TICK_DIV enabled cycles
module helo_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic en_i,
    output logic tick_o
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Count while enabled, wrap on terminal count, hold at zero whenever disabled
    always_comb begin
        tick_o = en_i && (cnt_q == LAST);
        cnt_d  = (!en_i || tick_o) ? '0 : cnt_q + 1'b1;
    end

    // Counter register; reset and disable both leave it at zero
    always_ff @(posedge Clock) begin
        if (!Resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/helo_scroll_ctrl.sv
// helo_scroll_ctrl: rotates the HELLO message across eight displays, automatically or by single steps
module helo_scroll_ctrl
    import helo_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Run,
    input  logic        Dir,
    input  logic        Step,
    output logic [23:0] Codes,
    output logic [2:0]  Pos,
    output logic        StepPulse
);

    state_e      state_q, state_d;
    logic        run_en, tick, shift;
    logic [23:0] codes_q, codes_d;
    logic [2:0]  pos_q, pos_d;
    logic        pulse_q;

    helo_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clock (Clock),
        .Resetn(Resetn),
        .en_i  (run_en),
        .tick_o(tick)
    );

    // State register
    always_ff @(posedge Clock) begin
        if (!Resetn) state_q <= ST_HOLD;
        else         state_q <= state_d;
    end

    // Next state simply follows the Run level in both states
    always_comb begin
        state_d = Run ? ST_RUN : ST_HOLD;
    end

    // Counting only continues while staying in RUN, so a falling Run drops the partial count without shifting
    always_comb begin
        run_en = (state_q == ST_RUN) && Run;
        shift  = (state_q == ST_RUN) ? tick : Step;
    end

    // Rotate by one 3-bit field; Dir is only consulted when a shift actually happens
    always_comb begin
        codes_d = shift ? (Dir ? {codes_q[2:0], codes_q[23:3]} : {codes_q[20:0], codes_q[23:21]}) : codes_q;
        pos_d   = shift ? (Dir ? pos_q - 3'd1 : pos_q + 3'd1) : pos_q;
    end

    // Message, offset and shift strobe registers feeding the outputs directly
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            codes_q <= BASE_MSG;
            pos_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            codes_q <= codes_d;
            pos_q   <= pos_d;
            pulse_q <= shift;
        end
    end

    assign Codes     = codes_q;
    assign Pos       = pos_q;
    assign StepPulse = pulse_q;

endmodule

// File: tb/tb_helo_scroll_ctrl.sv
// tb_helo_scroll_ctrl: directed stimulus with a pulse-driven scoreboard for helo_scroll_ctrl
module tb_helo_scroll_ctrl;

    localparam int TD = 4;
    localparam logic [23:0] BASE = 24'o12334000;

    typedef struct {
        int          edge_n;
        logic [23:0] codes;
        logic [2:0]  pos;
    } exp_t;

    logic        Clock = 1'b0;
    logic        Resetn = 1'b0;
    logic        Run = 1'b0;
    logic        Dir = 1'b0;
    logic        Step = 1'b0;
    logic [23:0] Codes;
    logic [2:0]  Pos;
    logic        StepPulse;

    exp_t sb[$];
    exp_t cur;
    int   edges = 0;
    int   checks = 0;
    int   fails = 0;
    int   base_e;

    helo_scroll_ctrl #(.TICK_DIV(TD)) dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .Run      (Run),
        .Dir      (Dir),
        .Step     (Step),
        .Codes    (Codes),
        .Pos      (Pos),
        .StepPulse(StepPulse)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) edges <= edges + 1;

    function automatic logic [23:0] rot(int p);
        logic [23:0] b;
        logic [23:0] r;
        b = BASE;
        r = '0;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = b[3*((i - p + 16) % 8) +: 3];
        return r;
    endfunction

    task automatic expect_shift(int at_edge, int p);
        exp_t e;
        e.edge_n = at_edge;
        e.codes  = rot(p % 8);
        e.pos    = 3'((p % 8));
        sb.push_back(e);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0o, expected %0o", name, act, exp);
        end
    endtask

    always @(negedge Clock) begin
        if (sb.size() > 0 && sb[0].edge_n < edges) begin
            checks++;
            fails++;
            $display("FAIL missed_shift: no StepPulse by edge %0d, expected at edge %0d", edges, sb[0].edge_n);
            void'(sb.pop_front());
        end
        if (StepPulse) begin
            checks++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_shift: StepPulse at edge %0d, Codes=%0o Pos=%0d, none expected", edges, Codes, Pos);
            end else begin
                cur = sb.pop_front();
                if (Codes !== cur.codes || Pos !== cur.pos || edges != cur.edge_n) begin
                    fails++;
                    $display("FAIL shift: got edge %0d Codes=%0o Pos=%0d, expected edge %0d Codes=%0o Pos=%0d",
                             edges, Codes, Pos, cur.edge_n, cur.codes, cur.pos);
                end
            end
        end
    end

    initial begin
        tick(2);
        check("reset_codes", 32'(Codes), 32'(BASE));
        check("reset_pos", 32'(Pos), 0);
        check("reset_pulse", 32'(StepPulse), 0);
        Resetn = 1'b1;

        Run = 1'b1;
        Dir = 1'b0;
        base_e = edges;
        for (int k = 1; k <= 8; k++) expect_shift(base_e + 1 + TD * k, k);
        tick(1 + TD * 8);
        Run = 1'b0;
        tick(1);
        check("left_wrap_codes", 32'(Codes), 32'(BASE));
        check("left_wrap_pos", 32'(Pos), 0);

        Resetn = 1'b0;
        tick(1);
        Resetn = 1'b1;
        Run = 1'b1;
        Dir = 1'b1;
        base_e = edges;
        expect_shift(base_e + 5, 7);
        tick(5);
        Run = 1'b0;
        tick(1);
        check("right_codes", 32'(Codes), 32'(24'o01233400));
        check("right_pos", 32'(Pos), 7);

        Resetn = 1'b0;
        tick(1);
        Resetn = 1'b1;
        Dir = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            Step = 1'b1;
            expect_shift(edges + 1, k);
            tick(1);
            Step = 1'b0;
            tick(1);
        end
        check("manual_codes", 32'(Codes), 32'(24'o34000123));
        check("manual_pos", 32'(Pos), 3);
        Step = 1'b1;
        expect_shift(edges + 1, 4);
        expect_shift(edges + 2, 5);
        tick(2);
        Step = 1'b0;
        tick(1);
        check("held_step_pos", 32'(Pos), 5);
        Run = 1'b1;
        base_e = edges;
        expect_shift(base_e + 5, 6);
        tick(1);
        Step = 1'b1;
        tick(1);
        Step = 1'b0;
        tick(3);
        Run = 1'b0;
        tick(1);
        check("run_ignores_step_pos", 32'(Pos), 6);

        Run = 1'b1;
        tick(3);
        Run = 1'b0;
        tick(2);
        check("interrupt_codes", 32'(Codes), 32'(rot(6)));
        Run = 1'b1;
        base_e = edges;
        expect_shift(base_e + 5, 7);
        tick(2);
        Dir = 1'b1;
        tick(1);
        Dir = 1'b0;
        tick(2);
        Run = 1'b0;
        tick(1);
        check("interrupt_pos", 32'(Pos), 7);

        Dir = 1'b1;
        Step = 1'b1;
        expect_shift(edges + 1, 6);
        expect_shift(edges + 2, 5);
        tick(2);
        Step = 1'b0;
        Dir = 1'b0;
        tick(1);
        check("pre_reset_pos", 32'(Pos), 5);
        Run = 1'b1;
        tick(3);
        Resetn = 1'b0;
        tick(1);
        check("midrun_reset_codes", 32'(Codes), 32'(BASE));
        check("midrun_reset_pos", 32'(Pos), 0);
        check("midrun_reset_pulse", 32'(StepPulse), 0);
        Resetn = 1'b1;
        base_e = edges;
        expect_shift(base_e + 5, 1);
        tick(5);
        Run = 1'b0;
        tick(3);
        check("scoreboard_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
